// File: rtl/simple_circuit_pkg.sv
// Shared types and constants for the simple_circuit self-test controller.
package simple_circuit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int          NUM_VEC        = 8;
   localparam logic [15:0] GOLDEN_DEFAULT = 16'hB333;

   // Expected {D,E} for vector idx, packed two bits per vector.
   function automatic logic [1:0] golden_de(input logic [15:0] golden_tab,
                                            input logic [2:0]  idx);
      return golden_tab[{idx, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/simple_circuit_checker_hold_counter.sv
// Per-vector hold timer: counts while enabled, flags the last cycle of a hold.
module hold_counter #(
   parameter int HOLD_CYCLES = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [7:0] TC_VAL = 8'(HOLD_CYCLES - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 8'd0;
      end else if (en_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/simple_circuit_checker.sv
// Self-test controller: sweeps all eight {A,B,C} vectors through simple_circuit
// and scores the {D,E} response against a golden table.
module simple_circuit_checker
   import simple_circuit_pkg::*;
#(
   parameter int          HOLD_CYCLES = 20,
   parameter logic [15:0] GOLDEN      = GOLDEN_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [2:0] abc,
   input  logic [1:0] de_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_fail,
   output logic       first_fail_valid
);

   state_e     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [2:0] abc_q, abc_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [3:0] err_q, err_d;
   logic [2:0] ff_q, ff_d;
   logic       ffv_q, ffv_d;

   logic       cnt_clr;
   logic       cnt_en;
   logic       hold_tc;
   logic       mismatch;

   hold_counter #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_hold_counter (
      .clk  (clk),
      .rst_n(rst_n),
      .clr_i(cnt_clr),
      .en_i (cnt_en),
      .tc_o (hold_tc)
   );

   assign mismatch = (de_in != golden_de(GOLDEN, idx_q));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      abc_d   = 3'd0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      ff_d    = ff_q;
      ffv_d   = ffv_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_DRIVE;
               idx_d   = 3'd0;
               busy_d  = 1'b1;
               pass_d  = 1'b0;
               err_d   = 4'd0;
               ff_d    = 3'd0;
               ffv_d   = 1'b0;
               cnt_clr = 1'b1;
            end
         end

         ST_DRIVE: begin
            cnt_en = 1'b1;
            abc_d  = idx_q;
            if (hold_tc) begin
               if (mismatch) begin
                  err_d = err_q + 4'd1;
                  if (!ffv_q) begin
                     ff_d  = idx_q;
                     ffv_d = 1'b1;
                  end
               end
               // Results are final at the last sample edge, so pass uses err_d.
               if (idx_q == 3'(NUM_VEC - 1)) begin
                  state_d = ST_DONE;
                  abc_d   = 3'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 4'd0);
               end else begin
                  idx_d   = idx_q + 3'd1;
                  abc_d   = idx_d;
                  cnt_clr = 1'b1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         abc_q   <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 4'd0;
         ff_q    <= 3'd0;
         ffv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         abc_q   <= abc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         ffv_q   <= ffv_d;
      end
   end

   assign abc              = abc_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail       = ff_q;
   assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_simple_circuit_checker.sv
// Bench for simple_circuit_checker: behavioural circuit with injectable faults,
// reference scoring computed from the boolean equations.
`timescale 1ns/1ps
module tb_simple_circuit_checker;

   localparam int HC_A = 20;
   localparam int HC_B = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_a, busy_a, done_a, pass_a, ffv_a;
   logic [2:0] abc_a, ff_a;
   logic [1:0] de_a;
   logic [3:0] err_a;
   logic       start_b, busy_b, done_b, pass_b, ffv_b;
   logic [2:0] abc_b, ff_b;
   logic [1:0] de_b;
   logic [3:0] err_b;

   // Circuit response tables, possibly corrupted per vector.
   logic [1:0] tab_a [8];
   logic [1:0] tab_b [8];
   assign de_a = tab_a[abc_a];
   assign de_b = tab_b[abc_b];

   simple_circuit_checker #(.HOLD_CYCLES(HC_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abc(abc_a), .de_in(de_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
      .first_fail(ff_a), .first_fail_valid(ffv_a)
   );

   simple_circuit_checker #(.HOLD_CYCLES(HC_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abc(abc_b), .de_in(de_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
      .first_fail(ff_b), .first_fail_valid(ffv_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // D = A&B | ~C, E = ~C
   function automatic logic [1:0] ref_de(input int i);
      logic a, b, c;
      a = i[2];
      b = i[1];
      c = i[0];
      return {(a & b) | ~c, ~c};
   endfunction

   task automatic check_reset_a(input string tag);
      check_val({tag, "_abc"}, abc_a, 0);
      check_val({tag, "_busy"}, busy_a, 0);
      check_val({tag, "_done"}, done_a, 0);
      check_val({tag, "_pass"}, pass_a, 0);
      check_val({tag, "_err"}, err_a, 0);
      check_val({tag, "_ff"}, ff_a, 0);
      check_val({tag, "_ffv"}, ffv_a, 0);
   endtask

   // mode: 0 golden, 1 D stuck 0, 2 E inverted, 3 vector 5 forced to 11, else random
   task automatic run_a(input int mode, input string name);
      int exp_err = 0;
      int exp_ff  = 0;
      int exp_ffv = 0;
      int k       = 0;
      bit got     = 0;
      for (int i = 0; i < 8; i++) begin
         case (mode)
            0:       tab_a[i] = ref_de(i);
            1:       tab_a[i] = ref_de(i) & 2'b01;
            2:       tab_a[i] = ref_de(i) ^ 2'b01;
            3:       tab_a[i] = (i == 5) ? 2'b11 : ref_de(i);
            default: tab_a[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : ref_de(i);
         endcase
         if (tab_a[i] != ref_de(i)) begin
            exp_err++;
            if (exp_ffv == 0) begin
               exp_ff  = i;
               exp_ffv = 1;
            end
         end
      end
      @(negedge clk) start_a = 1'b1;
      @(posedge clk);
      @(negedge clk) start_a = 1'b0;
      check_val("start_busy", busy_a, 1);
      check_val("start_abc", abc_a, 0);
      check_val("start_err_clr", err_a, 0);
      check_val("start_ffv_clr", ffv_a, 0);
      check_val("start_pass_clr", pass_a, 0);
      while (!got && k < 8 * HC_A + 10) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (done_a) begin
            got = 1;
         end else if (k < 8 * HC_A) begin
            check_val("abc_step", abc_a, k / HC_A);
         end
      end
      check_val("done_latency", got ? k : -1, 8 * HC_A);
      check_val("done_busy", busy_a, 0);
      check_val("err_count", err_a, exp_err);
      check_val("pass", pass_a, (exp_err == 0) ? 1 : 0);
      check_val("first_fail_valid", ffv_a, exp_ffv);
      check_val("first_fail", ff_a, exp_ff);
      @(posedge clk);
      @(negedge clk);
      check_val("done_pulse_width", done_a, 0);
      check_val("idle_abc", abc_a, 0);
      $display("run %s: err_count=%0d first_fail=%0d valid=%0d pass=%0d (expect %0d/%0d/%0d)",
               name, err_a, ff_a, ffv_a, pass_a, exp_err, exp_ff, exp_ffv);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int first_done;
      int second_done;
      int extra_done;
      int n_done;

      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tab_a[i] = ref_de(i);
         tab_b[i] = ref_de(i);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_a("reset");
      check_val("reset_busy_b", busy_b, 0);
      rst_n = 1'b1;
      $display("reset released");

      run_a(0, "golden");
      run_a(1, "d_stuck0");
      run_a(3, "vec5_forced11");
      run_a(2, "e_inverted");
      for (int r = 0; r < 10; r++) begin
         run_a(4, "random");
      end

      // start held high on the fast instance: back-to-back runs
      for (int i = 0; i < 8; i++) tab_b[i] = ref_de(i) & 2'b01;
      first_done  = -1;
      second_done = -1;
      extra_done  = 0;
      @(negedge clk) start_b = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done_b) begin
            if (first_done < 0) first_done = k;
            else if (second_done < 0) second_done = k;
            else extra_done++;
         end
         if (k == 16) begin
            check_val("b1_err", err_b, 5);
            check_val("b1_ff", ff_b, 0);
            check_val("b1_ffv", ffv_b, 1);
            check_val("b1_pass", pass_b, 0);
            for (int i = 0; i < 8; i++) tab_b[i] = ref_de(i);
         end
         if (k == 18) begin
            check_val("b2_busy", busy_b, 1);
            check_val("b2_err_clr", err_b, 0);
            check_val("b2_ffv_clr", ffv_b, 0);
            check_val("b2_abc", abc_b, 0);
         end
         if (k == 34) begin
            check_val("b2_err", err_b, 0);
            check_val("b2_pass", pass_b, 1);
            start_b = 1'b0;
         end
         if (k == 38) check_val("b_idle_busy", busy_b, 0);
      end
      check_val("b_first_done", first_done, 16);
      check_val("b_second_done", second_done, 34);
      check_val("b_extra_done", extra_done, 0);
      $display("held-start run: done at %0d and %0d", first_done, second_done);

      // reset in the middle of a run
      for (int i = 0; i < 8; i++) tab_a[i] = ref_de(i) ^ 2'b01;
      @(negedge clk) start_a = 1'b1;
      @(posedge clk);
      @(negedge clk) start_a = 1'b0;
      repeat (49) @(negedge clk);
      check_val("pre_reset_err", err_a, 2);
      check_val("pre_reset_busy", busy_a, 1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_a("midrun_reset");
      rst_n  = 1'b1;
      n_done = 0;
      for (int k = 0; k < 8 * HC_A + 20; k++) begin
         @(negedge clk);
         if (done_a) n_done++;
      end
      check_val("no_done_after_reset", n_done, 0);
      check_val("idle_after_reset", busy_a, 0);
      $display("mid-run reset: done pulses afterwards=%0d", n_done);
      run_a(0, "after_reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
